// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of a single SDRAM Avalon-MM master port, with read-return routing.
// Optional build macro ARB_FIXED_PRIO_EN: m0 wins IDLE ties and is never preempted.
module sdram_port_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int MAX_PEND = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        arb_error
);

  // state  | meaning
  // IDLE   | nobody granted, choose next owner
  // GRANT0 | m0 drives the master port
  // GRANT1 | m1 drives the master port
  // DRAIN  | wait for outstanding reads of the last owner to return
  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_DRAIN} state_t;

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PEND);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            err_q, err_d;

  logic        in_grant, gsel;
  logic        req0, req1, req_cur, req_oth;
  logic        cur_read, cur_write, rd_cur;
  logic [31:0] cur_addr, cur_wdata;
  logic        read_block, acc, acc_rd, pend_nz, beat_ok;
  logic        preempt_ok, tie_m0, release_g;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign in_grant  = (state_q == S_GRANT0) || (state_q == S_GRANT1);
  assign gsel      = (state_q == S_GRANT1);
  assign req_cur   = gsel ? req1 : req0;
  assign req_oth   = gsel ? req0 : req1;
  assign cur_read  = gsel ? m1_read : m0_read;
  assign cur_write = gsel ? m1_write : m0_write;
  assign cur_addr  = gsel ? m1_address : m0_address;
  assign cur_wdata = gsel ? m1_writedata : m0_writedata;
  // a write beat wins over a simultaneous read from the same requester
  assign rd_cur    = cur_read & ~cur_write;

  assign pend_nz    = (pend_q != '0);
  assign read_block = in_grant & rd_cur & (pend_q == PEND_FULL);
  assign acc        = (master_read | master_write) & ~master_waitrequest;
  assign acc_rd     = master_read & ~master_waitrequest;
  assign beat_ok    = master_readdatavalid & pend_nz;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_m0     = 1'b1;
  assign preempt_ok = gsel;
`else
  assign tie_m0     = last_q;
  assign preempt_ok = 1'b1;
`endif

  assign release_g = in_grant &
                     (~req_cur | (preempt_ok & (hold_q == HOLD_LAST) & acc & req_oth));

  always_comb begin
    pend_d = pend_q;
    if (acc_rd && !beat_ok)
      pend_d = pend_q + PW'(1);
    else if (!acc_rd && beat_ok)
      pend_d = pend_q - PW'(1);
  end

  assign err_d = err_q | (master_readdatavalid & ~pend_nz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (req0 && (!req1 || tie_m0)) begin
          state_d = S_GRANT0;
          owner_d = 1'b0;
        end else if (req1) begin
          state_d = S_GRANT1;
          owner_d = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        // saturate so a late-arriving competitor preempts on the next beat
        if (acc && (hold_q != HOLD_LAST))
          hold_d = hold_q + HW'(1);
        if (release_g) begin
          last_d  = gsel;
          hold_d  = '0;
          state_d = (pend_d != '0) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!pend_nz)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    master_address   = '0;
    master_writedata = '0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    if (in_grant) begin
      master_address   = cur_addr;
      master_writedata = cur_wdata;
      master_write     = cur_write;
      master_read      = rd_cur & ~read_block;
      if (gsel)
        m1_waitrequest = master_waitrequest | read_block;
      else
        m0_waitrequest = master_waitrequest | read_block;
    end
  end

  assign m0_readdata      = master_readdata;
  assign m1_readdata      = master_readdata;
  assign m0_readdatavalid = master_readdatavalid & ~owner_q & pend_nz;
  assign m1_readdatavalid = master_readdatavalid & owner_q & pend_nz;
  assign arb_error        = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter (MAX_HOLD=4, MAX_PEND=3); honours ARB_FIXED_PRIO_EN.
module tb_sdram_port_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int MAX_PEND = 3;
  localparam logic [31:0] RMASK = 32'h5A5A_5A5A;

  logic        clk, rst_n;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic        master_waitrequest, master_read, master_write, master_readdatavalid;
  logic [31:0] master_address, master_writedata, master_readdata;
  logic        arb_error;

  sdram_port_arbiter #(.MAX_HOLD(MAX_HOLD), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .arb_error(arb_error)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cmd_seen = 0;
  int rdv_seen = 0;
  int last_cmd_rdv = 0;
  bit resp_en = 1'b1;

  logic [65:0] exp_cmd[$];   // {write, read, address, writedata}
  logic [33:0] exp_rd[$];    // {m1_rdv, m0_rdv, readdata}
  int          rq_t[$];
  logic [31:0] rq_a[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bdata(input bit p, input int i);
    return 32'hD000_0000 | (32'(p) << 16) | 32'(i);
  endfunction

  task automatic push_beats(input bit p, input bit wr, input logic [31:0] base,
                            input int first, input int n);
    for (int i = first; i < first + n; i++)
      exp_cmd.push_back({wr, ~wr, base + 32'(4 * i), bdata(p, i)});
  endtask

  task automatic set_req(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      m1_address = a; m1_writedata = d; m1_write = wr; m1_read = ~wr;
    end else begin
      m0_address = a; m0_writedata = d; m0_write = wr; m0_read = ~wr;
    end
  endtask

  task automatic clr(input bit p);
    if (p) begin m1_read = 1'b0; m1_write = 1'b0; end
    else   begin m0_read = 1'b0; m0_write = 1'b0; end
  endtask

  // Avalon-style requester: holds each beat until waitrequest drops
  task automatic m_xfer(input bit p, input bit wr, input logic [31:0] base, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      set_req(p, wr, base + 32'(4 * i), bdata(p, i));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while ((p ? m1_waitrequest : m0_waitrequest) && t < 200);
      if (t >= 200) begin
        total++; bad++;
        $display("FAIL xfer_timeout port=%0d beat=%0d act=stalled exp=accepted", p, i);
        clr(p);
        return;
      end
      @(posedge clk); #1;
    end
    clr(p);
  endtask

  // monitor: pops the scoreboards whenever the DUT presents a beat
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if ((master_read || master_write) && !master_waitrequest) begin
        cmd_seen++;
        last_cmd_rdv = rdv_seen;
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected act=%h exp=none",
                   {master_write, master_read, master_address, master_writedata});
        end else
          chk("cmd", {master_write, master_read, master_address, master_writedata},
              exp_cmd.pop_front());
        if (resp_en && master_read) begin
          rq_t.push_back(cyc + 5);
          rq_a.push_back(master_address);
        end
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        rdv_seen++;
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rdv_unexpected act=%h exp=none",
                   {m1_readdatavalid, m0_readdatavalid, master_readdata});
        end else
          chk("rdv", {32'h0, m1_readdatavalid, m0_readdatavalid, master_readdata},
              {32'h0, exp_rd.pop_front()});
      end
    end
  end

  // SDRAM model: returns each accepted read 5 cycles later
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
          void'(rq_t.pop_front());
          master_readdatavalid = 1'b1;
          master_readdata = rq_a.pop_front() ^ RMASK;
        end else begin
          master_readdatavalid = 1'b0;
          master_readdata = 32'h0;
        end
      end
    end
  end

  initial begin
    int c0, rb, t;
    rst_n = 1'b0;
    m0_address = 32'h100; m0_writedata = 32'hCAFE_0001; m0_write = 1'b1; m0_read = 1'b0;
    m1_address = '0; m1_writedata = '0; m1_write = 1'b0; m1_read = 1'b0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
    exp_cmd.push_back({1'b1, 1'b0, 32'h100, 32'hCAFE_0001});

    // reset with a pending m0 write
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mwrite", master_write, 0);
    chk("rst_mread", master_read, 0);
    chk("rst_m0wait", m0_waitrequest, 1);
    chk("rst_m1wait", m1_waitrequest, 1);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    chk("rst_err", arb_error, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_mwrite", master_write, 0);
    chk("rel_m0wait", m0_waitrequest, 1);
    @(negedge clk);
    chk("gnt_mwrite", master_write, 1);
    chk("gnt_m0wait", m0_waitrequest, 0);
    @(posedge clk); #1 m0_write = 1'b0;
    repeat (2) @(posedge clk); #1;

    // single requester, 4 writes
    push_beats(0, 1, 32'h1000, 0, 4);
    fork
      m_xfer(0, 1, 32'h1000, 4);
      begin
        @(negedge clk); chk("lat_idle", master_write, 0);
        @(negedge clk); chk("lat_first", master_write, 1);
      end
    join
    @(negedge clk);
    @(negedge clk);
    chk("back_idle_wait", m0_waitrequest, 1);
    chk("back_idle_mwrite", master_write, 0);
    @(posedge clk); #1;

    // m1 reads with 5-cycle return; m0 must wait for the drain
    rb = rdv_seen;
    push_beats(1, 0, 32'h2000, 0, 3);
    for (int i = 0; i < 3; i++)
      exp_rd.push_back({1'b1, 1'b0, (32'h2000 + 32'(4 * i)) ^ RMASK});
    push_beats(0, 1, 32'h3000, 0, 1);
    m_xfer(1, 0, 32'h2000, 3);
    m_xfer(0, 1, 32'h3000, 1);
    chk("drain_hold", 32'(last_cmd_rdv - rb), 3);
    chk("pend_zero", dut.pend_q, 0);
    repeat (2) @(posedge clk); #1;

    // outstanding-read limit with no return
    resp_en = 1'b0;
    master_readdatavalid = 1'b0;
    push_beats(1, 0, 32'h4000, 0, 4);
    for (int k = 0; k < 4; k++) exp_rd.push_back({1'b1, 1'b0, 32'h0000_BEE0 + 32'(k)});
    c0 = cmd_seen;
    fork
      m_xfer(1, 0, 32'h4000, 4);
      begin
        t = 0;
        while ((cmd_seen - c0) < 3 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
          total++; bad++;
          $display("FAIL pend_fill_timeout act=%0d exp=3", cmd_seen - c0);
        end
        repeat (3) begin
          @(negedge clk);
          chk("stall_m1wait", m1_waitrequest, 1);
          chk("stall_mread", master_read, 0);
        end
        @(posedge clk); #1 master_readdatavalid = 1'b1; master_readdata = 32'h0000_BEE0;
        @(posedge clk); #1 master_readdatavalid = 1'b0;
      end
    join
    for (int k = 1; k < 4; k++) begin
      master_readdatavalid = 1'b1; master_readdata = 32'h0000_BEE0 + 32'(k);
      @(posedge clk); #1;
    end
    master_readdatavalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("stall_pend_zero", dut.pend_q, 0);
    chk("stall_err_clean", arb_error, 0);

    // both requesters continuously
`ifdef ARB_FIXED_PRIO_EN
    push_beats(0, 1, 32'h5000, 0, 8);
    push_beats(1, 1, 32'h6000, 0, 8);
`else
    push_beats(0, 1, 32'h5000, 0, 4);
    push_beats(1, 1, 32'h6000, 0, 4);
    push_beats(0, 1, 32'h5000, 4, 4);
    push_beats(1, 1, 32'h6000, 4, 4);
`endif
    fork
      m_xfer(0, 1, 32'h5000, 8);
      m_xfer(1, 1, 32'h6000, 8);
    join
    repeat (3) @(posedge clk); #1;

    // stray read beat with nothing outstanding
    master_readdatavalid = 1'b1; master_readdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("err_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    @(posedge clk); #1 master_readdatavalid = 1'b0;
    @(negedge clk);
    chk("err_set", arb_error, 1);
    chk("err_pend", dut.pend_q, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", arb_error, 1);

    chk("cmd_left", exp_cmd.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
